// File: rtl/scanned_segment_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scanned_segment_display                                      |
// | Description : Time-multiplexed common-anode 7-segment driver with per-digit|
// |               decimal point, blink and registered outputs.                 |
// |               Define SEG_LZB_EN to enable leading-zero blanking.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module scanned_segment_display #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] digits,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blink_mask,
    output logic [0:6]          segment,
    output logic [DIGITS-1:0]   anodes,
    output logic                decimal_point
);

    localparam int c_CNT_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = $clog2(DIGITS);
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [c_FRM_W-1:0] c_FRM_MAX = c_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_ONE = c_FRM_W'(1);
    localparam logic [DIGITS-1:0]  c_ANODE_ONE = {{(DIGITS-1){1'b0}}, 1'b1};
    localparam logic [0:6]         c_SEG_OFF = 7'b1111111;

    logic [c_CNT_W-1:0] r_refresh_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_FRM_W-1:0] r_frame_cnt;
    logic               r_blink_phase;

    logic               w_tick;
    logic               w_frame_end;
    logic [3:0]         w_nibble;
    logic [0:6]         w_glyph;
    logic [DIGITS-1:0]  w_lzb_vec;
    logic               w_dark;

    assign w_tick      = (r_refresh_cnt == c_CNT_MAX);
    assign w_frame_end = w_tick && (r_idx == c_IDX_MAX);

    // Scan and blink counters free-run regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_tick) begin
                r_refresh_cnt <= '0;
                r_idx         <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IDX_ONE;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + c_CNT_ONE;
            end
            if (w_frame_end) begin
                if (r_frame_cnt == c_FRM_MAX) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_FRM_ONE;
                end
            end
        end
    end

    assign w_nibble = digits[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_glyph = 7'b0110000;
        case (w_nibble)
            4'h0: w_glyph = 7'b0000001;
            4'h1: w_glyph = 7'b1001111;
            4'h2: w_glyph = 7'b0010010;
            4'h3: w_glyph = 7'b0000110;
            4'h4: w_glyph = 7'b1001100;
            4'h5: w_glyph = 7'b0100100;
            4'h6: w_glyph = 7'b0100000;
            4'h7: w_glyph = 7'b0001111;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0000100;
            default: w_glyph = 7'b0110000;
        endcase
    end

`ifdef SEG_LZB_EN
    // Walk down from the top digit; a digit blanks while every digit at or
    // above it is zero and its own decimal point is off. Digit 0 never blanks.
    always_comb begin : g_lzb
        logic w_zero_run;
        w_zero_run = 1'b1;
        w_lzb_vec  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zero_run   = w_zero_run && (digits[4*i +: 4] == 4'h0);
            w_lzb_vec[i] = w_zero_run && !dp_in[i];
        end
    end
`else
    assign w_lzb_vec = '0;
`endif

    assign w_dark = !enable || (blink_mask[r_idx] && r_blink_phase) || w_lzb_vec[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes        <= '1;
            segment       <= c_SEG_OFF;
            decimal_point <= 1'b1;
        end else if (w_dark) begin
            anodes        <= '1;
            segment       <= c_SEG_OFF;
            decimal_point <= 1'b1;
        end else begin
            anodes        <= ~(c_ANODE_ONE << r_idx);
            segment       <= w_glyph;
            decimal_point <= ~dp_in[r_idx];
        end
    end

endmodule
`default_nettype wire
